// File: rtl/instruction_fetch_unit_pkg.sv
// instruction_fetch_unit_pkg
// Shared definitions for the SPARC V8 fetch stage: FSM state encoding,
// the RAM opcode used for instruction reads, and word-size constants.
package instruction_fetch_unit_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    ERROR = 2'd3
  } fetch_state_t;

  localparam logic [5:0]  RAM_OP_LOAD_WORD = 6'b000000;
  localparam int          INSTR_WIDTH      = 32;
  localparam logic [31:0] WORD_BYTES       = 32'd4;

  // Control-transfer targets are always word aligned.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_pc_npc_regs.sv
// pc_npc_regs
// PC/NPC register pair implementing SPARC delayed control transfer.
// On advance, PC takes the old NPC (so the delay slot is always fetched)
// and NPC takes either the aligned redirect target or NPC+4 (wraps mod 2^32).
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   advance           current instruction consumed this cycle
//   redirect          control transfer taken (only meaningful with advance)
//   redirect_target   new NPC, low two bits dropped
//   pc, npc           current PC and NPC
module pc_npc_regs
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        advance,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic [31:0] pc,
  output logic [31:0] npc
);

  always_ff @(posedge clk) begin
    if (reset) begin
      pc  <= RESET_PC;
      npc <= RESET_PC + WORD_BYTES;
    end else if (advance) begin
      pc  <= npc;
      npc <= redirect ? word_align(redirect_target) : npc + WORD_BYTES;
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit
// Fetch stage ahead of the instruction register. Issues word reads to RAM at
// PC, waits for MFC, and holds the fetched word for the ControlUnit under a
// valid/ready handshake. A consume advances PC/NPC (with optional redirect).
// Optional feature macro: FETCH_TIMEOUT_EN -- when defined, a FETCH lasting
// MFC_TIMEOUT cycles without MFC lands in a sticky ERROR state.
// Ports:
//   Clk, RESET                 clock, synchronous active-high reset
//   ram_addr/opcode/enable     RAM read request (combinational from state/PC)
//   ram_data_in, MFC           RAM read data and completion strobe
//   ir_out, ir_valid, ir_ready instruction handshake toward ControlUnit
//   redirect, redirect_target  taken control transfer, sampled with consume
//   pc_out, npc_out            PC of the held/fetched instruction, NPC
//   fetch_error                sticky MFC timeout flag
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          MFC_TIMEOUT = 15
) (
  input  logic                   Clk,
  input  logic                   RESET,
  output logic [31:0]            ram_addr,
  output logic [5:0]             ram_opcode,
  output logic                   ram_enable,
  input  logic [INSTR_WIDTH-1:0] ram_data_in,
  input  logic                   MFC,
  output logic [INSTR_WIDTH-1:0] ir_out,
  output logic                   ir_valid,
  input  logic                   ir_ready,
  input  logic                   redirect,
  input  logic [31:0]            redirect_target,
  output logic [31:0]            pc_out,
  output logic [31:0]            npc_out,
  output logic                   fetch_error
);

  fetch_state_t state;
  logic         consume;

  // A consume only happens while an instruction is actually held.
  assign consume = (state == HOLD) && ir_ready;

  pc_npc_regs #(
    .RESET_PC(RESET_PC)
  ) u_pc_npc (
    .clk             (Clk),
    .reset           (RESET),
    .advance         (consume),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .pc              (pc_out),
    .npc             (npc_out)
  );

  assign ram_enable = (state == FETCH);
  assign ram_addr   = pc_out;
  assign ram_opcode = RAM_OP_LOAD_WORD;

`ifdef FETCH_TIMEOUT_EN
  localparam int CNT_W = $clog2(MFC_TIMEOUT + 1);

  logic [CNT_W-1:0] timeout_count;
  logic             error_flag;

  assign fetch_error = error_flag;

  // FSM with timeout; MFC is checked before the count so a word arriving
  // on the limiting cycle is still captured.
  always_ff @(posedge Clk) begin
    if (RESET) begin
      state         <= IDLE;
      ir_out        <= '0;
      ir_valid      <= 1'b0;
      timeout_count <= '0;
      error_flag    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          timeout_count <= '0;
          state         <= FETCH;
        end
        FETCH: begin
          if (MFC) begin
            ir_out   <= ram_data_in;
            ir_valid <= 1'b1;
            state    <= HOLD;
          end else begin
            timeout_count <= timeout_count + CNT_W'(1);
            if (timeout_count + CNT_W'(1) == CNT_W'(MFC_TIMEOUT)) begin
              error_flag <= 1'b1;
              state      <= ERROR;
            end
          end
        end
        HOLD: begin
          if (ir_ready) begin
            ir_valid      <= 1'b0;
            timeout_count <= '0;
            state         <= FETCH;
          end
        end
        ERROR: begin
          ir_valid <= 1'b0;
          state    <= ERROR;
        end
      endcase
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = (MFC_TIMEOUT != 0);
  assign fetch_error    = 1'b0;

  // FSM without timeout: FETCH waits for MFC indefinitely.
  always_ff @(posedge Clk) begin
    if (RESET) begin
      state    <= IDLE;
      ir_out   <= '0;
      ir_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: state <= FETCH;
        FETCH: begin
          if (MFC) begin
            ir_out   <= ram_data_in;
            ir_valid <= 1'b1;
            state    <= HOLD;
          end
        end
        HOLD: begin
          if (ir_ready) begin
            ir_valid <= 1'b0;
            state    <= FETCH;
          end
        end
        ERROR: begin
          ir_valid <= 1'b0;
          state    <= ERROR;
        end
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit
// Directed, table-driven bench for instruction_fetch_unit (RESET_PC = 0).
// The table walks reset, a held instruction, a redirect with delay slot and
// a delayed MFC; hand-written sequences cover mid-fetch reset, NPC wrap and
// the optional MFC timeout (FETCH_TIMEOUT_EN).
module tb_instruction_fetch_unit;

  logic        Clk;
  logic        RESET;
  logic [31:0] ram_addr;
  logic [5:0]  ram_opcode;
  logic        ram_enable;
  logic [31:0] ram_data_in;
  logic        MFC;
  logic [31:0] ir_out;
  logic        ir_valid;
  logic        ir_ready;
  logic        redirect;
  logic [31:0] redirect_target;
  logic [31:0] pc_out;
  logic [31:0] npc_out;
  logic        fetch_error;

  int compared;
  int mismatched;

  instruction_fetch_unit #(
    .RESET_PC    (32'h0000_0000),
    .MFC_TIMEOUT (15)
  ) dut (
    .Clk             (Clk),
    .RESET           (RESET),
    .ram_addr        (ram_addr),
    .ram_opcode      (ram_opcode),
    .ram_enable      (ram_enable),
    .ram_data_in     (ram_data_in),
    .MFC             (MFC),
    .ir_out          (ir_out),
    .ir_valid        (ir_valid),
    .ir_ready        (ir_ready),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .pc_out          (pc_out),
    .npc_out         (npc_out),
    .fetch_error     (fetch_error)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic        mfc;
    logic [31:0] data;
    logic        ready;
    logic        redir;
    logic [31:0] target;
    logic        expEn;
    logic [31:0] expAddr;
    logic        expValid;
    logic [31:0] expIr;
    logic [31:0] expPc;
    logic [31:0] expNpc;
  } vec_t;

  vec_t vecs [19];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic mfc, input logic [31:0] data, input logic ready,
                               input logic redir, input logic [31:0] target);
    MFC             = mfc;
    ram_data_in     = data;
    ir_ready        = ready;
    redirect        = redir;
    redirect_target = target;
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic checkFetch(input string name, input logic en, input logic [31:0] addr,
                            input logic valid, input logic [31:0] pc, input logic [31:0] npc);
    checkOutput({name, ".ram_enable"}, {31'd0, ram_enable}, {31'd0, en});
    checkOutput({name, ".ram_addr"}, ram_addr, addr);
    checkOutput({name, ".ir_valid"}, {31'd0, ir_valid}, {31'd0, valid});
    checkOutput({name, ".pc"}, pc_out, pc);
    checkOutput({name, ".npc"}, npc_out, npc);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;

    //            mfc data           rdy rd  target         en  addr          v   ir             pc            npc
    vecs[0]  = '{1'b1, 32'h8200_6003, 1'b0, 1'b0, 32'h0,       1'b0, 32'h0,   1'b0, 32'h0,         32'h0,   32'h4};
    vecs[1]  = '{1'b1, 32'h8200_6003, 1'b0, 1'b0, 32'h0,       1'b1, 32'h0,   1'b0, 32'h0,         32'h0,   32'h4};
    vecs[2]  = '{1'b0, 32'h0,         1'b0, 1'b1, 32'h300,     1'b0, 32'h0,   1'b1, 32'h8200_6003, 32'h0,   32'h4};
    vecs[3]  = '{1'b0, 32'h0,         1'b0, 1'b0, 32'h0,       1'b0, 32'h0,   1'b1, 32'h8200_6003, 32'h0,   32'h4};
    vecs[4]  = '{1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0,       1'b0, 32'h0,   1'b1, 32'h8200_6003, 32'h0,   32'h4};
    vecs[5]  = '{1'b0, 32'h0,         1'b0, 1'b0, 32'h0,       1'b0, 32'h0,   1'b1, 32'h8200_6003, 32'h0,   32'h4};
    vecs[6]  = '{1'b0, 32'h0,         1'b0, 1'b0, 32'h0,       1'b0, 32'h0,   1'b1, 32'h8200_6003, 32'h0,   32'h4};
    vecs[7]  = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0,       1'b0, 32'h0,   1'b1, 32'h8200_6003, 32'h0,   32'h4};
    vecs[8]  = '{1'b1, 32'hA000_0001, 1'b1, 1'b1, 32'h300,     1'b1, 32'h4,   1'b0, 32'h8200_6003, 32'h4,   32'h8};
    vecs[9]  = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0,       1'b0, 32'h4,   1'b1, 32'hA000_0001, 32'h4,   32'h8};
    vecs[10] = '{1'b1, 32'h1111_2222, 1'b0, 1'b0, 32'h0,       1'b1, 32'h8,   1'b0, 32'hA000_0001, 32'h8,   32'hC};
    vecs[11] = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h103,     1'b0, 32'h8,   1'b1, 32'h1111_2222, 32'h8,   32'hC};
    vecs[12] = '{1'b0, 32'h0,         1'b0, 1'b0, 32'h0,       1'b1, 32'hC,   1'b0, 32'h1111_2222, 32'hC,   32'h100};
    vecs[13] = '{1'b0, 32'h0,         1'b0, 1'b0, 32'h0,       1'b1, 32'hC,   1'b0, 32'h1111_2222, 32'hC,   32'h100};
    vecs[14] = '{1'b0, 32'h0,         1'b0, 1'b0, 32'h0,       1'b1, 32'hC,   1'b0, 32'h1111_2222, 32'hC,   32'h100};
    vecs[15] = '{1'b1, 32'h3333_4444, 1'b0, 1'b0, 32'h0,       1'b1, 32'hC,   1'b0, 32'h1111_2222, 32'hC,   32'h100};
    vecs[16] = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0,       1'b0, 32'hC,   1'b1, 32'h3333_4444, 32'hC,   32'h100};
    vecs[17] = '{1'b1, 32'h5555_6666, 1'b0, 1'b0, 32'h0,       1'b1, 32'h100, 1'b0, 32'h3333_4444, 32'h100, 32'h104};
    vecs[18] = '{1'b0, 32'h0,         1'b0, 1'b0, 32'h0,       1'b0, 32'h100, 1'b1, 32'h5555_6666, 32'h100, 32'h104};

    // Reset state.
    RESET = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    step();
    checkFetch("reset", 1'b0, 32'h0, 1'b0, 32'h0, 32'h4);
    checkOutput("reset.ir_out", ir_out, 32'h0);
    checkOutput("reset.fetch_error", {31'd0, fetch_error}, 32'h0);
    checkOutput("reset.ram_opcode", {26'd0, ram_opcode}, 32'h0);
    RESET = 1'b0;

    // Table: each row checks this cycle's outputs, then clocks.
    for (int i = 0; i < 19; i++) begin
      applyStimulus(vecs[i].mfc, vecs[i].data, vecs[i].ready, vecs[i].redir, vecs[i].target);
      #1;
      checkFetch($sformatf("row%0d", i), vecs[i].expEn, vecs[i].expAddr, vecs[i].expValid,
                 vecs[i].expPc, vecs[i].expNpc);
      checkOutput($sformatf("row%0d.ir_out", i), ir_out, vecs[i].expIr);
      step();
    end

    // Reset mid-FETCH, MFC arrives the following cycle and must be dropped.
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    step();
    checkFetch("midrst.pre", 1'b1, 32'h104, 1'b0, 32'h104, 32'h108);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    applyStimulus(1'b1, 32'hBAD0_BAD0, 1'b0, 1'b0, 32'h0);
    #1;
    checkFetch("midrst.idle", 1'b0, 32'h0, 1'b0, 32'h0, 32'h4);
    step();
    checkFetch("midrst.fetch", 1'b1, 32'h0, 1'b0, 32'h0, 32'h4);
    checkOutput("midrst.ir_out", ir_out, 32'h0);
    applyStimulus(1'b1, 32'h1234_5678, 1'b0, 1'b0, 32'h0);
    step();
    checkFetch("midrst.hold", 1'b0, 32'h0, 1'b1, 32'h0, 32'h4);
    checkOutput("midrst.ir_out2", ir_out, 32'h1234_5678);

    // NPC wrap: redirect to the last word, then advance past it.
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'hFFFF_FFFF);
    step();
    checkFetch("wrap.redir", 1'b1, 32'h4, 1'b0, 32'h4, 32'hFFFF_FFFC);
    applyStimulus(1'b1, 32'h0, 1'b0, 1'b0, 32'h0);
    step();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    step();
    checkFetch("wrap.top", 1'b1, 32'hFFFF_FFFC, 1'b0, 32'hFFFF_FFFC, 32'h0);
    applyStimulus(1'b1, 32'h0, 1'b0, 1'b0, 32'h0);
    step();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    step();
    checkFetch("wrap.zero", 1'b1, 32'h0, 1'b0, 32'h0, 32'h4);

`ifdef FETCH_TIMEOUT_EN
    // Timeout: 15 FETCH cycles without MFC -> sticky error; reset clears.
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    step();
    for (int i = 0; i < 14; i++) step();
    checkFetch("tmo.last", 1'b1, 32'h0, 1'b0, 32'h0, 32'h4);
    checkOutput("tmo.noerr", {31'd0, fetch_error}, 32'h0);
    step();
    checkOutput("tmo.err", {31'd0, fetch_error}, 32'h1);
    checkFetch("tmo.errstate", 1'b0, 32'h0, 1'b0, 32'h0, 32'h4);
    applyStimulus(1'b1, 32'h5A5A_5A5A, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 5; i++) step();
    checkOutput("tmo.sticky", {31'd0, fetch_error}, 32'h1);
    checkFetch("tmo.frozen", 1'b0, 32'h0, 1'b0, 32'h0, 32'h4);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    checkOutput("tmo.cleared", {31'd0, fetch_error}, 32'h0);
    // MFC on the limiting cycle wins.
    step();
    for (int i = 0; i < 14; i++) step();
    applyStimulus(1'b1, 32'hCAFE_F00D, 1'b0, 1'b0, 32'h0);
    step();
    checkOutput("tmo.mfcwins.err", {31'd0, fetch_error}, 32'h0);
    checkOutput("tmo.mfcwins.valid", {31'd0, ir_valid}, 32'h1);
    checkOutput("tmo.mfcwins.ir", ir_out, 32'hCAFE_F00D);
`else
    // Without the timeout, FETCH waits indefinitely and never errors.
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 20; i++) step();
    checkFetch("wait.long", 1'b1, 32'h0, 1'b0, 32'h0, 32'h4);
    checkOutput("wait.noerr", {31'd0, fetch_error}, 32'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Fetch stage ahead of the instruction register in the SPARC V8 datapath. Owns PC/NPC, issues word reads to RAM, waits for MFC, and presents the fetched word to the ControlUnit with a valid/ready handshake. Implements SPARC delayed control transfer: a redirect replaces NPC, not PC, so the delay-slot instruction is always fetched.

## Interface
- RESET_PC, 32'h0000_0000: PC value after reset; NPC resets to RESET_PC+4.
- MFC_TIMEOUT, 15: cycles waited for MFC before flagging an error (used only with the timeout feature).
- Clk  in  1  single clock, all state updates on rising edge.
- RESET  in  1  synchronous, active-high reset.
- ram_addr  out  32  fetch address, equals PC while fetching.
- ram_opcode  out  6  constant RAM_OP_LOAD_WORD (6'b000000).
- ram_enable  out  1  read request, high only in FETCH.
- ram_data_in  in  32  RAM read data, valid when MFC=1.
- MFC  in  1  memory function complete.
- ir_out  out  32  fetched instruction word.
- ir_valid  out  1  ir_out holds an unconsumed instruction.
- ir_ready  in  1  ControlUnit consumes ir_out this cycle.
- redirect  in  1  control transfer taken; sampled only with the consume.
- redirect_target  in  32  new NPC; bits [1:0] forced to 0.
- pc_out  out  32  PC of the instruction in ir_out / being fetched.
- npc_out  out  32  current NPC.
- fetch_error  out  1  sticky timeout flag.

## Operation
- States: IDLE, FETCH, HOLD, ERROR.
- IDLE: ram_enable=0, MFC ignored; next cycle -> FETCH. Entered only from reset.
- FETCH: ram_enable=1, ram_addr=PC. MFC=1 sampled -> ir_out<=ram_data_in, ir_valid<=1, -> HOLD.
- HOLD: ram_enable=0, ir_valid=1, ir_out stable. ir_ready=1 -> ir_valid<=0, PC<=NPC, NPC<=(redirect ? {redirect_target[31:2],2'b00} : NPC+4), -> FETCH.
- ir_ready while ir_valid=0 has no effect; redirect without simultaneous consume is ignored.
- NPC+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 0).
- MFC outside FETCH is ignored.
- ERROR: see Configuration.

## Timing
- Reset values: state IDLE, PC=RESET_PC, NPC=RESET_PC+4, ir_out=0, ir_valid=0, ram_enable=0, ram_addr=RESET_PC, fetch_error=0.
- RESET takes effect at the next edge regardless of state; in-flight fetch abandoned, a late MFC falls into IDLE and is ignored.
- ram_enable, ram_addr, ram_opcode are decoded combinationally from state/PC.
- ir_valid rises the edge after MFC is sampled; zero-wait RAM plus immediate ready gives one instruction per 2 cycles.
- First ram_enable: second cycle after RESET falls (IDLE occupies the first).
- pc_out/npc_out update on the same edge as the consume.

## Configuration
- FETCH_TIMEOUT_EN defined: a counter clears on entry to FETCH and increments each FETCH cycle with MFC=0; on reaching MFC_TIMEOUT -> ERROR. ERROR: ram_enable=0, ir_valid=0, fetch_error=1, PC/NPC frozen, leaves only on RESET. MFC on the cycle the count reaches the limit wins (instruction captured, no error).
- Undefined: FETCH waits indefinitely; no counter logic; fetch_error tied 0; ERROR unreachable.

## Structure
- Shared package/include: state encodings, RAM_OP_LOAD_WORD, INSTR_WIDTH=32, WORD_BYTES=4.
- Sub-module pc_npc_regs: PC/NPC pair with reset, advance, and redirect inputs; FSM and timeout counter stay in the top.

## Test plan
- Reset with RESET_PC=0, RAM word 0 = 32'h8200_6003, MFC same cycle as enable -> ram_enable first high in cycle 2, ir_valid high cycle 3, ir_out=32'h8200_6003, pc_out=0.
- Hold ir_ready=0 for 5 cycles -> ir_valid and ir_out stable, ram_enable=0 throughout; ready -> PC=4, NPC=8.
- Consume at PC=8 with redirect=1, target=32'h0000_0103 -> PC=12 (delay slot fetched), NPC=32'h0000_0100, next consume PC=32'h100.
- MFC delayed 3 cycles -> ram_enable high 4 cycles, ram_addr constant, ir_valid one cycle after MFC.
- FETCH_TIMEOUT_EN, MFC_TIMEOUT=15, MFC never asserted -> fetch_error=1 after 15 FETCH cycles, sticky; RESET clears it and PC=RESET_PC.
- RESET asserted mid-FETCH with MFC arriving next cycle -> ir_valid stays 0, word discarded, fetch restarts at RESET_PC.
